// File: rtl/game_timer_pkg.sv
// game_timer_pkg
//   Shared definitions for the Morse game timer scheduler: the channel state
//   encoding (the game FSM never uses T_WAIT) and the counter widths.
package game_timer_pkg;

  typedef enum logic [1:0] {
    T_IDLE = 2'd0,
    T_WAIT = 2'd1,
    T_RUN  = 2'd2,
    T_DONE = 2'd3
  } tstate_t;

  localparam int GAME_CNT_W = 7;
  localparam int SHOW_CNT_W = 4;

endpackage

// File: rtl/game_timer_sched_prescaler.sv
// tick_prescaler
//   Shared 1 s prescaler. Counts 0..TICK_DIV-1 while `run` is high and emits
//   a single-cycle `tick` on the last count; held at 0 while `run` is low.
//   Optional feature macro: GAME_TIMER_PAUSE_EN adds `pause`, which freezes
//   the count (keeping its phase) and suppresses `tick`.
// Ports:
//   clk   in  system clock
//   rst   in  asynchronous active-low reset
//   run   in  at least one timer channel is running
//   pause in  (GAME_TIMER_PAUSE_EN only) freeze the prescaler
//   tick  out one-cycle pulse once per TICK_DIV running cycles
module tick_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
`ifdef GAME_TIMER_PAUSE_EN
  input  logic pause,
`endif
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;
  logic          hold;

`ifdef GAME_TIMER_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  assign tick = run && !hold && (count == LAST);

  // Holding (rather than clearing) during pause keeps the period phase, so a
  // pause delays expiry by exactly its own length.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)               count <= '0;
    else if (!run)          count <= '0;
    else if (hold)          count <= count;
    else if (count == LAST) count <= '0;
    else                    count <= count + CW'(1);
  end

endmodule

// File: rtl/game_timer_sched.sv
// game_timer_sched
//   Timer scheduler for the Morse game controller. One shared prescaler
//   serves the game-length timer and two display windows; only one display
//   window runs at a time, with window 1 winning simultaneous requests.
//   Optional feature macro: GAME_TIMER_PAUSE_EN adds input `pause`.
// Ports:
//   clk               in  system clock
//   rst               in  asynchronous active-low reset
//   enable            in  game-timer request (level)
//   enable5_1/_2      in  display window requests (level)
//   pause             in  (GAME_TIMER_PAUSE_EN only) freeze all timing
//   timeout           out game time expired (level)
//   FiveSecTimeout_1  out window 1 expired (level)
//   FiveSecTimeout_2  out window 2 expired (level)
//   game_secs_left    out remaining game ticks, 0 outside RUN
//   show_busy         out a display window is running
module game_timer_sched
  import game_timer_pkg::*;
#(
  parameter int TICK_DIV  = 50_000_000,
  parameter int GAME_SECS = 60,
  parameter int SHOW_SECS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  enable5_1,
  input  logic                  enable5_2,
`ifdef GAME_TIMER_PAUSE_EN
  input  logic                  pause,
`endif
  output logic                  timeout,
  output logic                  FiveSecTimeout_1,
  output logic                  FiveSecTimeout_2,
  output logic [GAME_CNT_W-1:0] game_secs_left,
  output logic                  show_busy
);

  localparam logic [GAME_CNT_W-1:0] GAME_LOAD = GAME_CNT_W'(GAME_SECS);
  localparam logic [SHOW_CNT_W-1:0] SHOW_LOAD = SHOW_CNT_W'(SHOW_SECS);

  tstate_t               game_st, game_st_nx;
  logic [GAME_CNT_W-1:0] game_cnt, game_cnt_nx;
  tstate_t               show_st    [2];
  tstate_t               show_st_nx [2];
  logic [SHOW_CNT_W-1:0] show_cnt    [2];
  logic [SHOW_CNT_W-1:0] show_cnt_nx [2];

  logic [1:0] show_en, show_run, show_elig, show_grant;
  logic       any_run, tick;

  assign show_en     = {enable5_2, enable5_1};
  assign show_run[0] = (show_st[0] == T_RUN);
  assign show_run[1] = (show_st[1] == T_RUN);
  assign any_run     = (game_st == T_RUN) || (|show_run);

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .run  (any_run),
`ifdef GAME_TIMER_PAUSE_EN
    .pause(pause),
`endif
    .tick (tick)
  );

  // A channel in DONE does not block the other one; only RUN does.
  assign show_elig[0] = show_en[0] && (show_st[0] == T_IDLE || show_st[0] == T_WAIT) && !show_run[1];
  assign show_elig[1] = show_en[1] && (show_st[1] == T_IDLE || show_st[1] == T_WAIT) && !show_run[0];
  assign show_grant   = {show_elig[1] && !show_elig[0], show_elig[0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      game_st     <= T_IDLE;
      game_cnt    <= '0;
      show_st[0]  <= T_IDLE;
      show_st[1]  <= T_IDLE;
      show_cnt[0] <= '0;
      show_cnt[1] <= '0;
    end else begin
      game_st     <= game_st_nx;
      game_cnt    <= game_cnt_nx;
      show_st[0]  <= show_st_nx[0];
      show_st[1]  <= show_st_nx[1];
      show_cnt[0] <= show_cnt_nx[0];
      show_cnt[1] <= show_cnt_nx[1];
    end
  end

  // Game FSM: a dropped enable wins over everything, including the expiry
  // tick, so a request released on the expiry edge never raises `timeout`.
  always_comb begin
    game_st_nx  = game_st;
    game_cnt_nx = game_cnt;
    if (!enable) begin
      game_st_nx  = T_IDLE;
      game_cnt_nx = '0;
    end else begin
      case (game_st)
        T_IDLE: begin
          game_st_nx  = T_RUN;
          game_cnt_nx = GAME_LOAD;
        end
        T_RUN: begin
          if (tick) begin
            if (game_cnt == GAME_CNT_W'(1)) begin
              game_st_nx  = T_DONE;
              game_cnt_nx = '0;
            end else begin
              game_cnt_nx = game_cnt - GAME_CNT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Show FSMs: an ungranted request parks in WAIT and is re-evaluated every
  // cycle, so it starts on the edge after the other window leaves RUN.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      show_st_nx[i]  = show_st[i];
      show_cnt_nx[i] = show_cnt[i];
      if (!show_en[i]) begin
        show_st_nx[i]  = T_IDLE;
        show_cnt_nx[i] = '0;
      end else begin
        case (show_st[i])
          T_IDLE, T_WAIT: begin
            if (show_grant[i]) begin
              show_st_nx[i]  = T_RUN;
              show_cnt_nx[i] = SHOW_LOAD;
            end else begin
              show_st_nx[i]  = T_WAIT;
            end
          end
          T_RUN: begin
            if (tick) begin
              if (show_cnt[i] == SHOW_CNT_W'(1)) begin
                show_st_nx[i]  = T_DONE;
                show_cnt_nx[i] = '0;
              end else begin
                show_cnt_nx[i] = show_cnt[i] - SHOW_CNT_W'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign timeout          = (game_st == T_DONE);
  assign FiveSecTimeout_1 = (show_st[0] == T_DONE);
  assign FiveSecTimeout_2 = (show_st[1] == T_DONE);
  assign game_secs_left   = (game_st == T_RUN) ? game_cnt : '0;
  assign show_busy        = |show_run;

endmodule

// File: tb/tb_game_timer_sched.sv
// tb_game_timer_sched
//   Bench for game_timer_sched with TICK_DIV=4, GAME_SECS=6, SHOW_SECS=2.
//   A behavioural model predicts the outputs after every clock edge; the
//   expectation is queued and a monitor compares it with the DUT on the
//   following falling edge. Directed scenarios add latency/range checks.
//   Define GAME_TIMER_PAUSE_EN to build and exercise the pause variant.
module tb_game_timer_sched;

  localparam int TICK_DIV  = 4;
  localparam int GAME_SECS = 6;
  localparam int SHOW_SECS = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic       enable5_1 = 1'b0;
  logic       enable5_2 = 1'b0;
`ifdef GAME_TIMER_PAUSE_EN
  logic       pause = 1'b0;
`endif
  logic       timeout, FiveSecTimeout_1, FiveSecTimeout_2, show_busy;
  logic [6:0] game_secs_left;

  game_timer_sched #(
    .TICK_DIV (TICK_DIV),
    .GAME_SECS(GAME_SECS),
    .SHOW_SECS(SHOW_SECS)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .enable          (enable),
    .enable5_1       (enable5_1),
    .enable5_2       (enable5_2),
`ifdef GAME_TIMER_PAUSE_EN
    .pause           (pause),
`endif
    .timeout         (timeout),
    .FiveSecTimeout_1(FiveSecTimeout_1),
    .FiveSecTimeout_2(FiveSecTimeout_2),
    .game_secs_left  (game_secs_left),
    .show_busy       (show_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       timeout;
    logic       fto1;
    logic       fto2;
    logic       busy;
    logic [6:0] secs;
  } obs_t;

  obs_t exp_q[$];
  int   n_compared = 0;
  int   n_mismatched = 0;

  // Reference model: game 0=off 1=counting 2=expired;
  // windows 0=off 1=queued 2=counting 3=expired.
  int m_game, m_game_left, m_elapsed;
  int m_show[2];
  int m_show_left[2];

  bit r_e, r_1, r_2, r_p;
  int n_cyc;

  function automatic void model_reset();
    m_game = 0; m_game_left = 0; m_elapsed = 0;
    for (int i = 0; i < 2; i++) begin
      m_show[i] = 0; m_show_left[i] = 0;
    end
  endfunction

  function automatic void model_step(bit r, bit e, bit e1, bit e2, bit p);
    bit any_run, tick;
    bit req[2];
    bit elig[2];
    int winner;
    if (!r) begin
      model_reset();
      return;
    end
    any_run = (m_game == 1) || (m_show[0] == 2) || (m_show[1] == 2);
    tick    = any_run && !p && (m_elapsed == TICK_DIV - 1);
    if (!any_run) m_elapsed = 0;
    else if (!p)  m_elapsed = (m_elapsed + 1) % TICK_DIV;

    if (!e) begin
      m_game = 0; m_game_left = 0;
    end else if (m_game == 0) begin
      m_game = 1; m_game_left = GAME_SECS;
    end else if (m_game == 1 && tick) begin
      m_game_left--;
      if (m_game_left == 0) m_game = 2;
    end

    req[0] = e1; req[1] = e2;
    for (int i = 0; i < 2; i++)
      elig[i] = req[i] && (m_show[i] <= 1) && (m_show[1-i] != 2);
    winner = elig[0] ? 0 : (elig[1] ? 1 : -1);
    for (int i = 0; i < 2; i++) begin
      if (!req[i]) begin
        m_show[i] = 0; m_show_left[i] = 0;
      end else if (m_show[i] <= 1) begin
        if (winner == i) begin
          m_show[i] = 2; m_show_left[i] = SHOW_SECS;
        end else begin
          m_show[i] = 1;
        end
      end else if (m_show[i] == 2 && tick) begin
        m_show_left[i]--;
        if (m_show_left[i] == 0) m_show[i] = 3;
      end
    end
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.timeout = (m_game == 2);
    o.fto1    = (m_show[0] == 3);
    o.fto2    = (m_show[1] == 3);
    o.busy    = (m_show[0] == 2) || (m_show[1] == 2);
    o.secs    = (m_game == 1) ? 7'(m_game_left) : 7'd0;
    return o;
  endfunction

  function automatic bit cur_pause();
`ifdef GAME_TIMER_PAUSE_EN
    return pause;
`else
    return 1'b0;
`endif
  endfunction

  task automatic step();
    model_step(rst, enable, enable5_1, enable5_2, cur_pause());
    @(posedge clk);
    #1;
    exp_q.push_back(model_obs());
  endtask

  task automatic applyStimulus(input bit e, input bit e1, input bit e2, input bit p);
    enable    = e;
    enable5_1 = e1;
    enable5_2 = e2;
`ifdef GAME_TIMER_PAUSE_EN
    pause     = p;
`else
    if (p) $display("[TB] pause request ignored in this build");
`endif
    step();
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_compared++;
    if (actual != expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
    end
  endtask

  task automatic checkRange(input string name, input int actual, input int lo, input int hi);
    n_compared++;
    if (actual < lo || actual > hi) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, required %0d..%0d", name, actual, lo, hi);
    end
  endtask

  function automatic bit flag(input int sel);
    case (sel)
      0:       return timeout;
      1:       return FiveSecTimeout_1;
      default: return FiveSecTimeout_2;
    endcase
  endfunction

  // Steps with inputs unchanged until the selected flag is high; -1 on expiry.
  task automatic waitFlag(input int sel, input int limit, output int cycles);
    cycles = -1;
    for (int i = 1; i <= limit; i++) begin
      step();
      if (flag(sel)) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic waitSecs(input int value, input int limit, input string name);
    int seen;
    seen = 0;
    for (int i = 0; i < limit; i++) begin
      step();
      if (game_secs_left == 7'(value)) begin
        seen = 1;
        break;
      end
    end
    checkOutput(name, seen, 1);
  endtask

  task automatic monitor();
    obs_t e, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {timeout, FiveSecTimeout_1, FiveSecTimeout_2, show_busy, game_secs_left};
        n_compared++;
        if (a !== e) begin
          n_mismatched++;
          $display("[TB] FAIL scoreboard @%0t: got to=%b f1=%b f2=%b busy=%b secs=%0d, required to=%b f1=%b f2=%b busy=%b secs=%0d",
                   $time, a.timeout, a.fto1, a.fto2, a.busy, a.secs,
                   e.timeout, e.fto1, e.fto2, e.busy, e.secs);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    fork
      monitor();
    join_none

    for (int i = 0; i < 3; i++) step();
    rst = 1'b1;
    step();

    // Asynchronous reset while the game counter reads 3.
    applyStimulus(1, 0, 0, 0);
    waitSecs(3, 60, "t1_reach_cnt3");
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("t1_async_timeout", timeout, 0);
    checkOutput("t1_async_secs", game_secs_left, 0);
    checkOutput("t1_async_busy", show_busy, 0);
    model_reset();
    step();
    step();
    rst = 1'b1;
    step();
    checkOutput("t1_reload", game_secs_left, GAME_SECS);

    // Game expiry latency, hold, and clear.
    applyStimulus(0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    waitFlag(0, 40, n_cyc);
    checkRange("t2_timeout_latency", n_cyc, 21, 24);
    for (int i = 0; i < 3; i++) step();
    checkOutput("t2_timeout_hold", timeout, 1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("t2_timeout_clear", timeout, 0);

    // Simultaneous window requests: window 1 first, window 2 after.
    applyStimulus(0, 1, 1, 0);
    checkOutput("t3_busy", show_busy, 1);
    waitFlag(1, 20, n_cyc);
    checkRange("t3_fto1_latency", n_cyc, 5, 8);
    applyStimulus(0, 0, 1, 0);
    checkOutput("t3_ch2_run", show_busy, 1);
    checkOutput("t3_fto1_clear", FiveSecTimeout_1, 0);
    waitFlag(2, 20, n_cyc);
    checkRange("t3_fto2_latency", n_cyc, 5, 8);
    applyStimulus(0, 0, 0, 0);

    // Request dropped while queued is discarded.
    applyStimulus(0, 1, 1, 0);
    applyStimulus(0, 1, 0, 0);
    waitFlag(1, 20, n_cyc);
    checkRange("t4_fto1_latency", n_cyc, 4, 8);
    applyStimulus(0, 1, 0, 0);
    checkOutput("t4_busy_idle", show_busy, 0);
    checkOutput("t4_fto2_low", FiveSecTimeout_2, 0);
    applyStimulus(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step();
    checkOutput("t4_fto2_still_low", FiveSecTimeout_2, 0);

    // Game and window 1 expire on the same tick.
    applyStimulus(1, 0, 0, 0);
    waitSecs(2, 40, "t5_reach_cnt2");
    applyStimulus(1, 1, 0, 0);
    waitFlag(0, 20, n_cyc);
    checkOutput("t5_timeout_seen", timeout, 1);
    checkOutput("t5_fto1_same_edge", FiveSecTimeout_1, 1);
    applyStimulus(0, 0, 0, 0);

`ifdef GAME_TIMER_PAUSE_EN
    // Ten paused cycles delay the expiry by exactly ten cycles.
    applyStimulus(1, 0, 0, 0);
    waitSecs(4, 40, "t6_reach_cnt4");
    for (int i = 0; i < 10; i++) applyStimulus(1, 0, 0, 1);
    checkOutput("t6_secs_held", game_secs_left, 4);
    applyStimulus(1, 0, 0, 0);
    waitFlag(0, 40, n_cyc);
    checkOutput("t6_delay", 11 + n_cyc, 4 * TICK_DIV + 10);
    applyStimulus(0, 0, 0, 0);
`endif

    // Randomized request traffic against the model.
    r_e = 0; r_1 = 0; r_2 = 0; r_p = 0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 24) == 0) r_e = !r_e;
      if ($urandom_range(0, 14) == 0) r_1 = !r_1;
      if ($urandom_range(0, 14) == 0) r_2 = !r_2;
`ifdef GAME_TIMER_PAUSE_EN
      if ($urandom_range(0, 39) == 0) r_p = !r_p;
`endif
      applyStimulus(r_e, r_1, r_2, r_p);
    end

    applyStimulus(0, 0, 0, 0);
    @(negedge clk);
    #1;
    checkOutput("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
